// File: rtl/demux_1x4_router.sv
//==============================================================================
// Module  : demux_1x4_router
// Brief   : 1-to-4 valid/ready demultiplexer with one registered slot per
//           channel. Optional per-channel 8-bit output transfer counters are
//           enabled by defining DEMUX_XFER_CNT_EN.
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module demux_1x4_router #(
    parameter int W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_sel,
    input  logic [W-1:0]     in_data,
    output logic [3:0]       out_valid,
    input  logic [3:0]       out_ready,
    output logic [4*W-1:0]   out_data
`ifdef DEMUX_XFER_CNT_EN
    ,
    output logic [31:0]      xfer_cnt
`endif
);

    localparam int c_NUM_CH = 4;

    logic [c_NUM_CH-1:0]          valid_q, valid_d;
    logic [c_NUM_CH-1:0][W-1:0]   data_q,  data_d;
    logic [c_NUM_CH-1:0]          w_load;
    logic [c_NUM_CH-1:0]          w_drain;
    logic                         w_in_xfer;

    // Only the selected slot can stall the producer; a draining slot may be refilled.
    assign in_ready  = ~valid_q[in_sel] | out_ready[in_sel];
    assign w_in_xfer = in_valid & in_ready;

    always_comb begin
        w_load  = '0;
        w_drain = '0;
        valid_d = valid_q;
        data_d  = data_q;
        for (int k = 0; k < c_NUM_CH; k++) begin
            w_load[k]  = w_in_xfer && (in_sel == 2'(k));
            w_drain[k] = valid_q[k] & out_ready[k];
            valid_d[k] = w_load[k] | (valid_q[k] & ~w_drain[k]);
            if (w_load[k]) begin
                data_d[k] = in_data;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= '0;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign out_valid = valid_q;
    assign out_data  = data_q;

`ifdef DEMUX_XFER_CNT_EN
    logic [c_NUM_CH-1:0][7:0] cnt_q, cnt_d;

    // Counters wrap naturally at 8 bits.
    always_comb begin
        cnt_d = cnt_q;
        for (int k = 0; k < c_NUM_CH; k++) begin
            cnt_d[k] = cnt_q[k] + {7'd0, w_drain[k]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign xfer_cnt = cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_demux_1x4_router.sv
//==============================================================================
// Module  : tb_demux_1x4_router
// Brief   : Scoreboard bench for demux_1x4_router (counter checks when
//           DEMUX_XFER_CNT_EN is defined).
// Revision: 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_demux_1x4_router;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic [1:0]     in_sel;
    logic [W-1:0]   in_data;
    logic [3:0]     out_valid;
    logic [3:0]     out_ready;
    logic [4*W-1:0] out_data;
`ifdef DEMUX_XFER_CNT_EN
    logic [31:0]    xfer_cnt;
`endif

    int checks = 0;
    int passes = 0;

    logic [7:0] exp_q [4][$];

    demux_1x4_router #(.W(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data)
`ifdef DEMUX_XFER_CNT_EN
        ,
        .xfer_cnt  (xfer_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic flush();
        for (int k = 0; k < 4; k++) exp_q[k].delete();
    endtask

    // Monitor: every output handshake must match the oldest word sent to that channel.
    always @(negedge clk) begin
        if (!rst) begin
            for (int k = 0; k < 4; k++) begin
                if (out_valid[k] && out_ready[k]) begin
                    if (exp_q[k].size() == 0) begin
                        checks++;
                        $display("FAIL unexpected_out ch%0d: got %h expected nothing", k, out_data[k*W +: W]);
                    end else begin
                        chk($sformatf("out_data_ch%0d", k), 32'(out_data[k*W +: W]), 32'(exp_q[k].pop_front()));
                    end
                end
            end
        end
    end

    // Drives one word; records it as expected at the edge where it is accepted.
    task automatic send(input logic [1:0] s, input logic [7:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_sel   = s;
        in_data  = d;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            $display("FAIL send_timeout ch%0d: in_ready got 0 expected 1", s);
        end else begin
            exp_q[s].push_back(d);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic do_reset(input int cycles);
        rst = 1'b1;
        repeat (cycles) @(posedge clk);
        #1;
        rst = 1'b0;
        flush();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = 2'd0; in_data = '0; out_ready = 4'b0000;
        @(posedge clk); #1;
        do_reset(2);

        // Reset and idle
        @(negedge clk);
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_out_data",  out_data, 32'h0);
        chk("reset_in_ready",  32'(in_ready), 32'h1);
`ifdef DEMUX_XFER_CNT_EN
        chk("reset_xfer_cnt", xfer_cnt, 32'h0);
`endif
        @(posedge clk); #1;

        // Routing into four stalled channels
        for (int k = 0; k < 4; k++) send(2'(k), 8'hA0 + 8'(k));
        @(negedge clk);
        chk("route_out_valid", 32'(out_valid), 32'hF);
        chk("route_out_data",  out_data, 32'hA3A2A1A0);
        @(posedge clk); #1;

        // Drain channel 1 only
        out_ready = 4'b0010;
        @(posedge clk); #1;
        out_ready = 4'b0000;
        @(negedge clk);
        chk("drain1_out_valid", 32'(out_valid), 32'hD);
        @(posedge clk); #1;

        // Backpressure on full channel 2
        in_valid = 1'b1; in_sel = 2'd2; in_data = 8'h55;
        @(negedge clk);
        chk("bp_in_ready_sel2", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_ch2_held", 32'(out_data[23:16]), 32'hA2);
        chk("bp_in_ready_still0", 32'(in_ready), 32'h0);
        @(posedge clk); #1;
        in_sel = 2'd1;
        @(negedge clk);
        chk("bp_in_ready_sel1", 32'(in_ready), 32'h1);
        exp_q[1].push_back(8'h55);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_out_valid", 32'(out_valid), 32'hF);
        chk("bp_ch1_data", 32'(out_data[15:8]), 32'h55);
        chk("bp_ch2_data", 32'(out_data[23:16]), 32'hA2);
        @(posedge clk); #1;

        // Simultaneous drain and fill on channel 3
        out_ready = 4'b1000;
        send(2'd3, 8'h11);
        send(2'd3, 8'h22);
        out_ready = 4'b0000;
        @(negedge clk);
        chk("df_out_valid3", 32'(out_valid[3]), 32'h1);
        chk("df_ch3_data", 32'(out_data[31:24]), 32'h22);
        @(posedge clk); #1;

        // Reset while all slots full and a word is offered
        in_valid = 1'b1; in_sel = 2'd0; in_data = 8'h77;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; in_valid = 1'b0;
        flush();
        @(negedge clk);
        chk("rst_mid_out_valid", 32'(out_valid), 32'h0);
        chk("rst_mid_out_data",  out_data, 32'h0);
        chk("rst_mid_in_ready",  32'(in_ready), 32'h1);
        @(posedge clk); #1;
        out_ready = 4'b1111;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_mid_no_delivery", 32'(out_valid), 32'h0);
        @(posedge clk); #1;

        // Full-throughput stream with every consumer ready
        send(2'd0, 8'h01);
        send(2'd2, 8'h02);
        send(2'd2, 8'h03);
        send(2'd1, 8'h04);
        send(2'd3, 8'h05);
        send(2'd0, 8'h06);
        @(negedge clk);
        chk("stream_out_valid", 32'(out_valid), 32'h1);
        chk("stream_ch0_data", 32'(out_data[7:0]), 32'h06);
        repeat (2) @(posedge clk);
        #1;

`ifdef DEMUX_XFER_CNT_EN
        do_reset(1);
        out_ready = 4'b0001;
        for (int i = 0; i < 255; i++) send(2'd0, 8'(i));
        @(negedge clk);
        chk("cnt_before_last", xfer_cnt, 32'h0000_00FE);
        @(posedge clk); #1;
        @(negedge clk);
        chk("cnt_255", xfer_cnt, 32'h0000_00FF);
        @(posedge clk); #1;
        send(2'd0, 8'hFF);
        @(posedge clk); #1;
        @(negedge clk);
        chk("cnt_wrap", xfer_cnt, 32'h0);
        @(posedge clk); #1;
`endif

        out_ready = 4'b0000;
        @(negedge clk);
        for (int k = 0; k < 4; k++) chk($sformatf("sb_empty_ch%0d", k), 32'(exp_q[k].size()), 32'h0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

`default_nettype wire
